// File: rtl/sdx_kernel_wizard_0_stream_alu.sv
// Pipelined AXI4-Stream lane ALU.
// Each beat is split into lanes and one operation is applied per packet:
// add-wrap, sub-wrap, add-saturate or pass, with a control constant that is
// latched on the first beat of every packet. A chain of registered stages
// with a combinational ready chain carries the result to the master port.
// Output handshakes drive beat/packet counters and a sticky saturation flag.
//
// Handshake semantics (both ports): a beat transfers on a rising edge where
// tvalid and tready are both 1. A master never drops tvalid and never changes
// tdata/tkeep/tlast while tvalid=1 and tready=0. Ready may depend on valid.
module sdx_kernel_wizard_0_stream_alu #(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_LANE_WIDTH       = 32,
    parameter int C_PIPE_STAGES      = 2
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic [C_LANE_WIDTH-1:0]         ctrl_constant,
    input  logic [1:0]                      ctrl_mode,
    input  logic                            ctrl_stat_clear,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                            s_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                            m_axis_tlast,
    output logic [31:0]                     stat_beat_count,
    output logic [31:0]                     stat_pkt_count,
    output logic                            stat_sat_flag
);

    localparam int DW = C_AXIS_TDATA_WIDTH;
    localparam int LW = C_LANE_WIDTH;
    localparam int NS = C_PIPE_STAGES;
    localparam int KW = DW / 8;
    localparam int NL = DW / LW;

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_SUB  = 2'b01;
    localparam logic [1:0] MODE_SAT  = 2'b10;

    // Reject parameter combinations the lane slicing cannot support.
    generate
        if ((DW % LW) != 0 || (LW % 8) != 0 || LW < 8 || LW > 64 || NS < 1 || NS > 4) begin : g_param_check
            $error("sdx_kernel_wizard_0_stream_alu: illegal parameter combination");
        end
    endgenerate

    // Handshakes
    logic s_hs;
    logic m_hs;

    // Per-packet control latch
    logic              in_packet_q, in_packet_d;
    logic [1:0]        mode_q, mode_d;
    logic [LW-1:0]     const_q, const_d;
    logic [1:0]        op_mode;
    logic [LW-1:0]     op_const;

    // Lane ALU results
    logic [DW-1:0]     alu_data;
    logic              alu_sat;
    logic [LW-1:0]     lane_d;
    logic [LW:0]       lane_sum;
    logic [LW-1:0]     lane_res;

    // Pipeline stages
    logic [NS-1:0]     valid_q;
    logic [NS-1:0]     last_q;
    logic [NS-1:0]     sat_q;
    logic [DW-1:0]     data_q [NS];
    logic [KW-1:0]     keep_q [NS];
    logic [NS-1:0]     load;
    logic              ready_chain;

    // Statistics
    logic [31:0]       beat_cnt_q;
    logic [31:0]       pkt_cnt_q;
    logic              sat_flag_q;

    assign s_hs = s_axis_tvalid && s_axis_tready;
    assign m_hs = m_axis_tvalid && m_axis_tready;

    // The first beat of a packet uses the live control inputs; later beats use the latch.
    assign op_mode  = in_packet_q ? mode_q  : ctrl_mode;
    assign op_const = in_packet_q ? const_q : ctrl_constant;

    // Next-state of the control latch: capture on a packet's first beat, release on tlast.
    always_comb begin
        in_packet_d = in_packet_q;
        mode_d      = mode_q;
        const_d     = const_q;
        if (s_hs) begin
            if (!in_packet_q) begin
                mode_d  = ctrl_mode;
                const_d = ctrl_constant;
            end
            in_packet_d = !s_axis_tlast;
        end
    end

    // Control latch registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            in_packet_q <= 1'b0;
            mode_q      <= 2'b00;
            const_q     <= '0;
        end else begin
            in_packet_q <= in_packet_d;
            mode_q      <= mode_d;
            const_q     <= const_d;
        end
    end

    // Per-lane operation; every lane is computed regardless of tkeep.
    always_comb begin
        alu_data = '0;
        alu_sat  = 1'b0;
        lane_d   = '0;
        lane_sum = '0;
        lane_res = '0;
        for (int i = 0; i < NL; i++) begin
            lane_d   = s_axis_tdata[i*LW +: LW];
            lane_sum = {1'b0, lane_d} + {1'b0, op_const};
            case (op_mode)
                MODE_ADD: lane_res = lane_sum[LW-1:0];
                MODE_SUB: lane_res = lane_d - op_const;
                MODE_SAT: begin
                    if (lane_sum[LW]) begin
                        lane_res = '1;
                        alu_sat  = 1'b1;
                    end else begin
                        lane_res = lane_sum[LW-1:0];
                    end
                end
                default:  lane_res = lane_d;
            endcase
            alu_data[i*LW +: LW] = lane_res;
        end
    end

    // Ready chain: a stage loads when it is empty or the stage after it loads.
    always_comb begin
        load        = '0;
        ready_chain = m_axis_tready;
        for (int k = NS - 1; k >= 0; k--) begin
            ready_chain = !valid_q[k] || ready_chain;
            load[k]     = ready_chain;
        end
    end

    assign s_axis_tready = load[0];

    // Stage 0 takes the ALU result, later stages are pure delay.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            valid_q <= '0;
            last_q  <= '0;
            sat_q   <= '0;
            for (int k = 0; k < NS; k++) begin
                data_q[k] <= '0;
                keep_q[k] <= '0;
            end
        end else begin
            if (load[0]) begin
                valid_q[0] <= s_axis_tvalid;
                data_q[0]  <= alu_data;
                keep_q[0]  <= s_axis_tkeep;
                last_q[0]  <= s_axis_tlast;
                sat_q[0]   <= alu_sat;
            end
            for (int k = 1; k < NS; k++) begin
                if (load[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    data_q[k]  <= data_q[k-1];
                    keep_q[k]  <= keep_q[k-1];
                    last_q[k]  <= last_q[k-1];
                    sat_q[k]   <= sat_q[k-1];
                end
            end
        end
    end

    assign m_axis_tvalid = valid_q[NS-1];
    assign m_axis_tdata  = data_q[NS-1];
    assign m_axis_tkeep  = keep_q[NS-1];
    assign m_axis_tlast  = last_q[NS-1];

    // Statistics on output handshakes; a clear pulse wins over counting.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            beat_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            sat_flag_q <= 1'b0;
        end else if (ctrl_stat_clear) begin
            beat_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            sat_flag_q <= 1'b0;
        end else if (m_hs) begin
            beat_cnt_q <= beat_cnt_q + 32'd1;
            if (m_axis_tlast) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
            if (sat_q[NS-1]) begin
                sat_flag_q <= 1'b1;
            end
        end
    end

    assign stat_beat_count = beat_cnt_q;
    assign stat_pkt_count  = pkt_cnt_q;
    assign stat_sat_flag   = sat_flag_q;

endmodule
